// File: rtl/cds_row_streamer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | cds_row_streamer: captures a column-parallel ADC row (reset+signal or      |
// | signal only), applies clamped digital CDS and streams LANES pixels/beat.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module cds_row_streamer #(
  parameter int ARRAY_WIDTH   = 10,
  parameter int ARRAY_HEIGHT  = 10,
  parameter int COUNTER_WIDTH = 8,
  parameter int LANES         = 1
) (
  input  logic                                 system_clk,
  input  logic                                 reset,
  input  logic                                 enable,
  input  logic                                 cds,
  input  logic [ARRAY_WIDTH*COUNTER_WIDTH-1:0] row_data,
  input  logic                                 row_reset_valid,
  input  logic                                 row_signal_valid,
  output logic                                 row_ready,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [LANES*COUNTER_WIDTH-1:0]       out_data,
  output logic                                 out_sol,
  output logic                                 out_eol,
  output logic                                 out_sof,
  output logic                                 out_eof,
  output logic [$clog2(ARRAY_HEIGHT)-1:0]      row_index,
  output logic                                 seq_error
);

  localparam int c_CW        = COUNTER_WIDTH;
  localparam int c_BEATS     = ARRAY_WIDTH / LANES;
  localparam int c_BEAT_W    = (c_BEATS > 1) ? $clog2(c_BEATS) : 1;
  localparam int c_ROW_W     = $clog2(ARRAY_HEIGHT);
  localparam int c_BEAT_BITS = LANES * c_CW;
  localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(c_BEATS - 1);
  localparam logic [c_ROW_W-1:0]  c_LAST_ROW  = c_ROW_W'(ARRAY_HEIGHT - 1);

  generate
    if (ARRAY_WIDTH % LANES != 0) begin : g_lane_check
      $error("ARRAY_WIDTH must be a multiple of LANES");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_RST = 2'd1,
    S_WAIT_SIG = 2'd2,
    S_STREAM   = 2'd3
  } state_t;

  state_t                       r_state, w_next_state;
  logic                         r_mode_cds;
  logic [c_ROW_W-1:0]           r_row_index;
  logic [c_BEAT_W-1:0]          r_beat;
  logic [ARRAY_WIDTH*c_CW-1:0]  r_rst_buf, r_pix_buf, w_pix_next;
  logic                         r_seq_error;
  logic                         w_cap_rst, w_cap_sig, w_set_err, w_frame_start, w_xfer;
  logic                         w_last_beat, w_last_row;

  // Per-column CDS: signal minus reset, clamped at zero instead of wrapping.
  generate
    for (genvar c = 0; c < ARRAY_WIDTH; c++) begin : g_col
      logic [c_CW-1:0] w_sig, w_rst;
      assign w_sig = row_data[c*c_CW +: c_CW];
      assign w_rst = r_rst_buf[c*c_CW +: c_CW];
      assign w_pix_next[c*c_CW +: c_CW] = !r_mode_cds        ? w_sig :
                                          (w_sig >= w_rst)   ? w_sig - w_rst : '0;
    end
  endgenerate

  assign w_last_beat = (r_beat == c_LAST_BEAT);
  assign w_last_row  = (r_row_index == c_LAST_ROW);

  always_ff @(posedge system_clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state  = r_state;
    w_cap_rst     = 1'b0;
    w_cap_sig     = 1'b0;
    w_set_err     = 1'b0;
    w_frame_start = 1'b0;
    w_xfer        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable) begin
          w_frame_start = 1'b1;
          w_next_state  = cds ? S_WAIT_RST : S_WAIT_SIG;
        end
      end
      S_WAIT_RST: begin
        w_set_err = row_signal_valid;
        if (row_reset_valid) begin
          w_cap_rst    = 1'b1;
          w_next_state = S_WAIT_SIG;
        end
      end
      S_WAIT_SIG: begin
        w_set_err = row_reset_valid && !row_signal_valid;
        if (row_signal_valid) begin
          w_cap_sig    = 1'b1;
          w_next_state = S_STREAM;
        end
      end
      S_STREAM: begin
        w_set_err = row_reset_valid || row_signal_valid;
        w_xfer    = out_ready;
        if (out_ready && w_last_beat) begin
          if (!w_last_row) begin
            w_next_state = r_mode_cds ? S_WAIT_RST : S_WAIT_SIG;
          end else if (enable) begin
            // Back-to-back frames re-sample cds at the frame boundary.
            w_frame_start = 1'b1;
            w_next_state  = cds ? S_WAIT_RST : S_WAIT_SIG;
          end else begin
            w_next_state = S_IDLE;
          end
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge system_clk) begin
    if (reset) begin
      r_mode_cds  <= 1'b0;
      r_row_index <= '0;
      r_beat      <= '0;
      r_rst_buf   <= '0;
      r_pix_buf   <= '0;
      r_seq_error <= 1'b0;
    end else begin
      if (w_frame_start) r_mode_cds  <= cds;
      if (w_set_err)     r_seq_error <= 1'b1;
      if (w_cap_rst)     r_rst_buf   <= row_data;
      if (w_cap_sig) begin
        r_pix_buf <= w_pix_next;
        r_beat    <= '0;
      end
      if (w_xfer) begin
        if (w_last_beat) begin
          r_beat      <= '0;
          r_row_index <= w_last_row ? '0 : r_row_index + 1'b1;
        end else begin
          r_beat <= r_beat + 1'b1;
        end
      end
      if (w_frame_start) r_row_index <= '0;
    end
  end

  assign row_ready = (r_state == S_WAIT_RST) || (r_state == S_WAIT_SIG);
  assign out_valid = (r_state == S_STREAM);
  assign out_data  = r_pix_buf[int'(r_beat) * c_BEAT_BITS +: c_BEAT_BITS];
  assign out_sol   = out_valid && (r_beat == '0);
  assign out_eol   = out_valid && w_last_beat;
  assign out_sof   = out_sol && (r_row_index == '0);
  assign out_eof   = out_eol && w_last_row;
  assign row_index = r_row_index;
  assign seq_error = r_seq_error;

endmodule
`default_nettype wire

// File: tb/tb_cds_row_streamer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_cds_row_streamer: scoreboard bench, 10x10 array, 8-bit samples, 2 lanes.|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_cds_row_streamer;

  localparam int W = 10, H = 10, CW = 8, L = 2, NB = W / L;
  typedef logic [W*CW-1:0] row_t;
  typedef struct packed {
    logic [L*CW-1:0] data;
    logic [3:0]      mark;   // {sol, eol, sof, eof}
    logic [3:0]      row;
  } beat_t;

  logic            system_clk = 1'b0;
  logic            reset = 1'b1, enable = 1'b0, cds = 1'b0;
  row_t            row_data = '0;
  logic            row_reset_valid = 1'b0, row_signal_valid = 1'b0, out_ready = 1'b1;
  logic            row_ready, out_valid, out_sol, out_eol, out_sof, out_eof, seq_error;
  logic [L*CW-1:0] out_data;
  logic [3:0]      row_index;

  int    n_tests = 0, n_fail = 0, beats_seen = 0, exp_row = 0;
  bit    mode_model = 1'b0, bp_toggle = 1'b0;
  row_t  rst_model = '0;
  beat_t sb[$];

  cds_row_streamer #(
    .ARRAY_WIDTH(W), .ARRAY_HEIGHT(H), .COUNTER_WIDTH(CW), .LANES(L)
  ) u_dut (
    .system_clk(system_clk), .reset(reset), .enable(enable), .cds(cds),
    .row_data(row_data), .row_reset_valid(row_reset_valid),
    .row_signal_valid(row_signal_valid), .row_ready(row_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sol(out_sol), .out_eol(out_eol), .out_sof(out_sof), .out_eof(out_eof),
    .row_index(row_index), .seq_error(seq_error)
  );

  always #5 system_clk = ~system_clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [CW-1:0] px(input row_t s, input row_t r, input bit m, input int c);
    int sv, rv, d;
    sv = int'(s[c*CW +: CW]);
    rv = int'(r[c*CW +: CW]);
    d  = m ? sv - rv : sv;
    return (d < 0) ? '0 : CW'(d);
  endfunction

  task automatic push_row(input row_t s);
    beat_t e;
    for (int b = 0; b < NB; b++) begin
      for (int k = 0; k < L; k++) e.data[k*CW +: CW] = px(s, rst_model, mode_model, b*L + k);
      e.mark = {b == 0, b == NB-1, (b == 0) && (exp_row == 0), (b == NB-1) && (exp_row == H-1)};
      e.row  = 4'(exp_row);
      sb.push_back(e);
    end
    exp_row = (exp_row + 1) % H;
  endtask

  task automatic tick();
    @(posedge system_clk);
    #1;
    out_ready = bp_toggle ? ~out_ready : 1'b1;
  endtask

  task automatic wait_rr(input string tag);
    int n = 0;
    while (!row_ready && n < 200) begin tick(); n++; end
    check_eq(tag, row_ready, 1);
  endtask

  task automatic send_row(input bit is_rst, input row_t d);
    wait_rr(is_rst ? "rr_wait_rst" : "rr_wait_sig");
    row_data = d;
    if (is_rst) begin
      row_reset_valid = 1'b1;
      rst_model       = d;
    end else begin
      row_signal_valid = 1'b1;
      push_row(d);
      check_eq("valid_pre_capture", out_valid, 0);
    end
    tick();
    row_reset_valid  = 1'b0;
    row_signal_valid = 1'b0;
    if (!is_rst) check_eq("valid_latency", out_valid, 1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin tick(); n++; end
    check_eq("drain", sb.size(), 0);
  endtask

  // Output monitor: scoreboard pop on transfer, stability under back-pressure.
  bit              stall_prev = 1'b0;
  logic [L*CW-1:0] held_data;
  logic [3:0]      held_mark;
  always @(negedge system_clk) begin
    beat_t e;
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check_eq("hold_valid", out_valid, 1);
        check_eq("hold_data", {out_data, out_sol, out_eol, out_sof, out_eof}, {held_data, held_mark});
      end
      if (out_valid) check_eq("rr_during_stream", row_ready, 0);
      if (out_valid && out_ready) begin
        beats_seen++;
        if (sb.size() == 0) begin
          check_eq("unexpected_beat", 1, 0);
        end else begin
          e = sb.pop_front();
          check_eq("beat_data", out_data, e.data);
          check_eq("beat_mark", {out_sol, out_eol, out_sof, out_eof}, e.mark);
          check_eq("beat_row", row_index, e.row);
        end
      end
      stall_prev = out_valid && !out_ready;
      held_data  = out_data;
      held_mark  = {out_sol, out_eol, out_sof, out_eof};
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    row_t r, d;
    int   base, n;
    int   rb[W] = '{0, 255, 100, 100, 255, 0, 1, 0, 7, 8};
    int   sbnd[W] = '{255, 0, 100, 99, 255, 0, 0, 1, 8, 7};

    repeat (3) tick();
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_row_ready", row_ready, 0);
    check_eq("rst_seq_error", seq_error, 0);
    check_eq("rst_row_index", row_index, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_markers", {out_sol, out_eol, out_sof, out_eof}, 0);
    reset = 1'b0;
    tick();
    check_eq("idle_row_ready", row_ready, 0);

    // Frame A: CDS mode, clamp patterns, back-pressure, protocol errors, enable drop.
    cds = 1'b1; enable = 1'b1; mode_model = 1'b1; exp_row = 0;
    tick();
    for (int rr = 0; rr < H; rr++) begin
      bp_toggle = (rr == 2) || (rr == 5);
      for (int c = 0; c < W; c++) begin
        if (rr == 0) begin
          r[c*CW +: CW] = 8'd20;
          d[c*CW +: CW] = CW'(10 * c);
        end else if (rr == 1) begin
          r[c*CW +: CW] = CW'(rb[c]);
          d[c*CW +: CW] = CW'(sbnd[c]);
        end else begin
          r[c*CW +: CW] = CW'($urandom_range(255));
          d[c*CW +: CW] = CW'($urandom_range(255));
        end
      end
      if (rr == 4) begin
        wait_rr("rr_before_err");
        row_data = {W{8'hAA}};
        row_signal_valid = 1'b1;
        tick();
        row_signal_valid = 1'b0;
        check_eq("err_sig_in_wait_rst", seq_error, 1);
        check_eq("err_ignored_ready", row_ready, 1);
        check_eq("err_ignored_index", row_index, 4);
      end
      send_row(1'b1, r);
      send_row(1'b0, d);
      if (rr == 3) enable = 1'b0;
      if (rr == 4) begin
        row_data = '1;
        row_reset_valid = 1'b1;
        tick();
        row_reset_valid = 1'b0;
        check_eq("rst_in_stream_ignored", out_valid, 1);
      end
    end
    bp_toggle = 1'b0;
    wait_drain();
    repeat (3) tick();
    check_eq("frameA_idle_ready", row_ready, 0);
    check_eq("frameA_idle_valid", out_valid, 0);
    check_eq("frameA_idle_index", row_index, 0);
    check_eq("seq_error_sticky", seq_error, 1);

    // Frame B: pass-through, cds flipped mid-frame must not matter.
    cds = 1'b0; mode_model = 1'b0; enable = 1'b1;
    tick();
    check_eq("frameB_wait_sig_ready", row_ready, 1);
    check_eq("frameB_row0", row_index, 0);
    base = beats_seen;
    for (int rr = 0; rr < H; rr++) begin
      bp_toggle = (rr == 6);
      for (int c = 0; c < W; c++) d[c*CW +: CW] = CW'(rr * 10 + c);
      if (rr == 8) cds = 1'b1;
      send_row(1'b0, d);
    end
    mode_model = 1'b1;
    bp_toggle  = 1'b0;
    wait_drain();
    check_eq("frameB_beat_count", beats_seen - base, 50);

    // Frame C: continuous start in CDS mode, reset at beat 4.
    for (int c = 0; c < W; c++) begin
      r[c*CW +: CW] = 8'd5;
      d[c*CW +: CW] = CW'(50 + 3 * c);
    end
    send_row(1'b1, r);
    base = beats_seen;
    send_row(1'b0, d);
    n = 0;
    while (beats_seen < base + 4 && n < 100) begin tick(); n++; end
    check_eq("reached_beat4", beats_seen - base, 4);
    reset = 1'b1;
    tick();
    sb.delete();
    exp_row = 0;
    check_eq("midrst_valid", out_valid, 0);
    check_eq("midrst_index", row_index, 0);
    check_eq("midrst_seq_error", seq_error, 0);
    check_eq("midrst_ready", row_ready, 0);
    reset = 1'b0; cds = 1'b0; mode_model = 1'b0; enable = 1'b1;
    tick();
    for (int c = 0; c < W; c++) d[c*CW +: CW] = CW'(200 - c);
    send_row(1'b0, d);
    enable = 1'b0;
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cds_row_streamer.md
Name: cds_row_streamer

Overview:
- Row-level readout back end for the column-parallel ramp-ADC pixel array.
- Captures one full row of column counter values, either as a reset sample plus a signal sample, or as a signal sample only.
- Applies digital correlated double sampling (CDS): signal minus reset, clamped at zero.
- Streams the row out as `lanes` pixels per beat over a valid/ready interface, with start/end-of-line and start/end-of-frame markers.
- Successor to the single-lane, non-handshaked read/pixel_out path: adds multiple lanes, back-pressure, framing and protocol-error detection.

Parameters:
- array_width, 10, pixels per row (columns).
- array_height, 10, rows per frame.
- counter_width, 8, bits per ADC sample.
- lanes, 1, pixels per output beat; array_width % lanes == 0 is required (elaboration-time assertion).

Ports:
- system_clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- enable  in  1  high = start or continue frames; low = stop after the current frame.
- cds  in  1  1 = digital CDS (reset row then signal row); 0 = signal row passed through.
- row_data  in  array_width*counter_width  column samples; column c at bits [c*counter_width +: counter_width].
- row_reset_valid  in  1  row_data holds reset-level samples.
- row_signal_valid  in  1  row_data holds signal-level samples.
- row_ready  out  1  block can accept a row in its current state.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  lanes*counter_width  lane k = pixel column (beat*lanes + k).
- out_sol / out_eol  out  1  first / last beat of a row.
- out_sof / out_eof  out  1  first beat of row 0 / last beat of the last row.
- row_index  out  $clog2(array_height)  row currently captured or streamed.
- seq_error  out  1  sticky protocol-error flag; cleared only by reset.

Behaviour:
- Reset values: all outputs 0, state IDLE, all counters 0, sample buffers 0.
- State IDLE:
  - row_ready = 0.
  - If enable = 1: latch cds into mode_cds, set row_index = 0, go to WAIT_RST if mode_cds = 1, otherwise WAIT_SIG.
- State WAIT_RST:
  - row_ready = 1.
  - row_reset_valid = 1: store row_data into rst_buf, go to WAIT_SIG.
  - row_signal_valid alone: ignored, seq_error set.
  - Both valids high: reset sample taken, seq_error set.
- State WAIT_SIG:
  - row_ready = 1.
  - row_signal_valid = 1: for each column, pix_buf[c] = mode_cds ? (sig >= rst ? sig - rst : 0) : sig. Registered; go to STREAM with beat = 0.
  - row_reset_valid alone: ignored, seq_error set.
- State STREAM:
  - row_ready = 0. Any row valid in this state is ignored and sets seq_error.
  - out_valid = 1 starting the cycle after signal capture (1-cycle latency).
  - out_data = pix_buf columns [beat*lanes +: lanes].
  - Markers:
    - out_sol = (beat == 0).
    - out_eol = (beat == array_width/lanes - 1).
    - out_sof = out_sol && row_index == 0.
    - out_eof = out_eol && row_index == array_height - 1.
  - Beat transfers only when out_valid && out_ready. While out_ready = 0, out_data and all markers hold stable.
  - Transfer on a non-last beat: beat++.
  - Transfer on the last beat, row not last: row_index++, go to WAIT_RST or WAIT_SIG (per mode_cds), out_valid = 0 the next cycle.
  - Transfer on the last beat of the last row: row_index wraps to 0.
    - enable = 1: latch cds again and go to WAIT_RST/WAIT_SIG (continuous frames).
    - enable = 0: go to IDLE.
- enable = 0 mid-frame: the frame completes normally, then the block goes to IDLE.
- cds changes mid-frame: no effect until the next frame start.
- reset asserted in any state: back to IDLE on the next edge. The partial row is discarded, out_valid drops, seq_error clears.
- Arithmetic: unsigned counter_width subtraction with no wrap. Result range is 0..2^counter_width-1.
- Throughput:
  - One beat per cycle when out_ready is held high.
  - Minimum row period in CDS mode: array_width/lanes + 2 cycles (a reset and a signal capture cycle).

Test Plan:
- CDS clamp, width 10, lanes 1, cds 1: reset row all 20, signal row columns 0..9 = 10*c → 10 beats 0,0,0,10,20,...,70; out_sol on beat 0, out_eol on beat 9; out_valid rises exactly 1 cycle after signal capture.
- Pass-through, cds 0, lanes 2, 10x10 frame: signal row r col c = r*10+c → 5 beats per row, lane0 = even column, lane1 = odd column; out_sof only on row 0 beat 0; out_eof only on row 9 beat 4; 50 beats total.
- Back-pressure: out_ready toggled 0/1 every cycle during a row → no beat lost or duplicated; out_data held constant while out_ready = 0; row_ready stays 0 until the last beat transfers.
- Protocol errors: row_signal_valid in WAIT_RST → ignored, seq_error = 1 and sticky; row_reset_valid during STREAM → ignored; a subsequent correct sequence still streams correct data.
- Frame control: enable low during row 3 → rows 3..9 still streamed, then IDLE with row_ready = 0; enable high again with cds = 0 → new frame starts at row 0 in WAIT_SIG.
- Reset mid-STREAM at beat 4 → next cycle out_valid = 0, row_index = 0, seq_error = 0, state IDLE; a new frame after release streams correct values.
